// File: rtl/ofm_out_fsm.sv
// ofm_out_fsm: TX offload output stage.
//   Pops one frame (ctrl word + data beats) from the FWFT ctrl/data FIFOs.
//   It stores the beats while accumulating the RFC1071 sum, folds the sum,
//   inserts the checksum, then replays the frame to the 10G MAC on AXI-Stream.
// Build option:
//   OFM_CSUM_EN  defined   : store-and-forward with checksum insertion and
//                            an oversize frame drop.
//                undefined : cut-through. The ctrl word is popped and ignored.
//                            frame_drop stays 0. There is no frame size limit.
// Ports:
//   mm2s_clk, mm2s_resetn     clock, async active-low reset
//   ctrl_fifo_*               ctrl word {CsCntrl, CsInit, CsInsert, CsBegin}, rden pops
//   data_fifo_*               data beat {last, keep[7:0], data[63:0]}, rden pops
//   tx_t*                     AXI-Stream master to the MAC
//   frame_drop                one-cycle pulse when an oversize frame is discarded
module ofm_out_fsm #(
  parameter int unsigned C_BUF_AW = 9
) (
  input  logic        mm2s_clk,
  input  logic        mm2s_resetn,
  input  logic [63:0] ctrl_fifo_rdata,
  input  logic        ctrl_fifo_empty,
  output logic        ctrl_fifo_rden,
  input  logic [72:0] data_fifo_rdata,
  input  logic        data_fifo_empty,
  output logic        data_fifo_rden,
  output logic [63:0] tx_tdata,
  output logic [7:0]  tx_tkeep,
  output logic        tx_tvalid,
  output logic        tx_tlast,
  input  logic        tx_tready,
  output logic        frame_drop
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FOLD, S_SEND, S_DROP, S_PASS} state_t;

  state_t state;
  logic   tx_fire;
  logic   tx_free;
  logic   unused_ok;

  assign tx_fire = tx_tvalid & tx_tready;
  assign tx_free = ~tx_tvalid | tx_tready;

`ifdef OFM_CSUM_EN
  localparam int unsigned DEPTH = 1 << C_BUF_AW;

  logic [72:0]         beat_mem [DEPTH];
  logic [72:0]         mem_q;
  logic                mem_v;
  logic                mem_move;
  logic                rd_en;
  logic                rd_done;
  logic [C_BUF_AW-1:0] cnt;
  logic [C_BUF_AW-1:0] last_addr;
  logic [C_BUF_AW-1:0] rd_addr;
  logic [C_BUF_AW-1:0] out_idx;
  logic [15:0]         cs_begin;
  logic [15:0]         cs_insert;
  logic                cs_en;
  logic                ins_ok;
  logic                fold_step;
  logic [31:0]         sum;
  logic [17:0]         beat_sum;
  logic [15:0]         csum;
  logic [7:0]          pop_keep;
  logic [63:0]         send_data;

  assign unused_ok = ^ctrl_fifo_rdata[63:49];
  assign pop_keep  = data_fifo_rdata[71:64];
  assign csum      = ~sum[15:0];
  assign data_fifo_rden = ~data_fifo_empty & ((state == S_LOAD) | (state == S_DROP));
  // RAM output stage refills whenever it is empty or drains this cycle
  assign mem_move  = mem_v & tx_free;
  assign rd_en     = (state == S_SEND) & ~rd_done & (~mem_v | tx_free);

  // Big-endian word contribution of the current beat: even offset = high byte
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < 8; i++) begin
      if (pop_keep[i] && (16'({cnt, 3'(i)}) >= cs_begin)) begin
        if ((i % 2) == 0) beat_sum = beat_sum + 18'({data_fifo_rdata[8*i +: 8], 8'h00});
        else              beat_sum = beat_sum + 18'(data_fifo_rdata[8*i +: 8]);
      end
    end
  end

  // Checksum overlay on the beat that holds CsInsert
  always_comb begin
    send_data = mem_q[63:0];
    if (ins_ok && (13'(out_idx) == cs_insert[15:3])) begin
      for (int j = 0; j < 4; j++) begin
        if (cs_insert[2:1] == 2'(j)) begin
          send_data[16*j +: 8]     = csum[15:8];
          send_data[16*j + 8 +: 8] = csum[7:0];
        end
      end
    end
  end

  // Beat buffer: written while loading, synchronous read while sending
  always_ff @(posedge mm2s_clk) begin
    if (data_fifo_rden && (state == S_LOAD)) beat_mem[cnt] <= data_fifo_rdata;
    if (rd_en) mem_q <= beat_mem[rd_addr];
  end
`else
  assign unused_ok = ^{ctrl_fifo_rdata, 32'(C_BUF_AW)};
  assign data_fifo_rden = ~data_fifo_empty & (state == S_PASS) & tx_free;
`endif

  // Control FSM and registered outputs
  always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
    if (!mm2s_resetn) begin
      state          <= S_IDLE;
      ctrl_fifo_rden <= 1'b0;
      frame_drop     <= 1'b0;
      tx_tdata       <= '0;
      tx_tkeep       <= '0;
      tx_tvalid      <= 1'b0;
      tx_tlast       <= 1'b0;
`ifdef OFM_CSUM_EN
      mem_v     <= 1'b0;
      rd_done   <= 1'b0;
      cnt       <= '0;
      last_addr <= '0;
      rd_addr   <= '0;
      out_idx   <= '0;
      cs_begin  <= '0;
      cs_insert <= '0;
      cs_en     <= 1'b0;
      ins_ok    <= 1'b0;
      fold_step <= 1'b0;
      sum       <= '0;
`endif
    end else begin
      ctrl_fifo_rden <= 1'b0;
      frame_drop     <= 1'b0;
      if (tx_fire) tx_tvalid <= 1'b0;
`ifdef OFM_CSUM_EN
      if (rd_en) begin
        rd_addr <= rd_addr + 1'b1;
        if (rd_addr == last_addr) rd_done <= 1'b1;
      end
      if (rd_en)         mem_v <= 1'b1;
      else if (mem_move) mem_v <= 1'b0;
      if (mem_move) begin
        tx_tdata  <= send_data;
        tx_tkeep  <= mem_q[71:64];
        tx_tlast  <= mem_q[72];
        tx_tvalid <= 1'b1;
        out_idx   <= out_idx + 1'b1;
      end
      case (state)
        // ctrl_fifo_rden guard: empty flag still shows the word being popped
        S_IDLE: if (!ctrl_fifo_empty && !ctrl_fifo_rden) begin
          cs_begin  <= ctrl_fifo_rdata[15:0];
          cs_insert <= ctrl_fifo_rdata[31:16];
          sum       <= 32'(ctrl_fifo_rdata[47:32]);
          cs_en     <= ctrl_fifo_rdata[48] & ~ctrl_fifo_rdata[16];
          ins_ok    <= 1'b0;
          cnt       <= '0;
          state     <= S_LOAD;
        end
        S_LOAD: if (data_fifo_rden) begin
          sum <= sum + 32'(beat_sum);
          cnt <= cnt + 1'b1;
          // Insertion needs both checksum bytes inside the frame
          if (cs_en && (13'(cnt) == cs_insert[15:3]) && pop_keep[{cs_insert[2:1], 1'b1}])
            ins_ok <= 1'b1;
          if (data_fifo_rdata[72]) begin
            last_addr <= cnt;
            fold_step <= 1'b0;
            state     <= S_FOLD;
          end else if (&cnt) begin
            state <= S_DROP;
          end
        end
        S_FOLD: begin
          sum       <= 32'(sum[15:0]) + 32'(sum[31:16]);
          fold_step <= 1'b1;
          if (fold_step) begin
            ctrl_fifo_rden <= 1'b1;
            rd_addr        <= '0;
            rd_done        <= 1'b0;
            out_idx        <= '0;
            state          <= S_SEND;
          end
        end
        S_SEND: if (tx_fire && tx_tlast) state <= S_IDLE;
        S_DROP: if (data_fifo_rden && data_fifo_rdata[72]) begin
          ctrl_fifo_rden <= 1'b1;
          frame_drop     <= 1'b1;
          state          <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
`else
      case (state)
        S_IDLE: if (!ctrl_fifo_empty && !ctrl_fifo_rden) begin
          ctrl_fifo_rden <= 1'b1;
          state          <= S_PASS;
        end
        S_PASS: if (data_fifo_rden) begin
          tx_tdata  <= data_fifo_rdata[63:0];
          tx_tkeep  <= data_fifo_rdata[71:64];
          tx_tlast  <= data_fifo_rdata[72];
          tx_tvalid <= 1'b1;
          if (data_fifo_rdata[72]) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_ofm_out_fsm.sv
`timescale 1ns/1ps
module tb_ofm_out_fsm;

  localparam int unsigned AW = 9;
  typedef logic [7:0] byte_q_t [$];

  logic        mm2s_clk = 1'b0;
  logic        mm2s_resetn;
  logic [63:0] ctrl_fifo_rdata;
  logic        ctrl_fifo_empty;
  logic        ctrl_fifo_rden;
  logic [72:0] data_fifo_rdata;
  logic        data_fifo_empty;
  logic        data_fifo_rden;
  logic [63:0] tx_tdata;
  logic [7:0]  tx_tkeep;
  logic        tx_tvalid;
  logic        tx_tlast;
  logic        tx_tready;
  logic        frame_drop;

  ofm_out_fsm #(.C_BUF_AW(AW)) dut (
    .mm2s_clk        (mm2s_clk),
    .mm2s_resetn     (mm2s_resetn),
    .ctrl_fifo_rdata (ctrl_fifo_rdata),
    .ctrl_fifo_empty (ctrl_fifo_empty),
    .ctrl_fifo_rden  (ctrl_fifo_rden),
    .data_fifo_rdata (data_fifo_rdata),
    .data_fifo_empty (data_fifo_empty),
    .data_fifo_rden  (data_fifo_rden),
    .tx_tdata        (tx_tdata),
    .tx_tkeep        (tx_tkeep),
    .tx_tvalid       (tx_tvalid),
    .tx_tlast        (tx_tlast),
    .tx_tready       (tx_tready),
    .frame_drop      (frame_drop)
  );

  always #5 mm2s_clk = ~mm2s_clk;

  logic [63:0] cq [$];
  logic [72:0] dq [$];
  logic [72:0] expq [$];
  logic [72:0] gotq [$];
  int          checks = 0;
  int          errors = 0;
  int          drops = 0;
  int          exp_drops = 0;
  int          cyc = 0;
  int          rdy_pct = 100;
  int          first_valid = -1;
  logic        stall_prev = 1'b0;
  logic [72:0] stall_beat = '0;

  // Reference checksum: big-endian 16-bit word sum from CsBegin, end-around carry
  function automatic logic [15:0] ref_csum(input byte_q_t fb, input logic [15:0] cb,
                                           input logic [15:0] init);
    longint unsigned s;
    s = 64'(init);
    for (int o = 0; o < fb.size(); o++)
      if (o >= int'(cb)) s += ((o % 2) == 0) ? (64'(fb[o]) << 8) : 64'(fb[o]);
    while (s > 64'd65535) s = (s & 64'd65535) + (s >> 16);
    return ~s[15:0];
  endfunction

  task automatic refresh();
    ctrl_fifo_empty = (cq.size() == 0);
    ctrl_fifo_rdata = (cq.size() == 0) ? 64'h0 : cq[0];
    data_fifo_empty = (dq.size() == 0);
    data_fifo_rdata = (dq.size() == 0) ? 73'h0 : dq[0];
  endtask

  // One clock: sample outputs at the falling edge, update FIFOs after the rising edge
  task automatic step();
    logic rd_d, rd_c;
    @(negedge mm2s_clk);
    rd_d = data_fifo_rden;
    rd_c = ctrl_fifo_rden;
    if (mm2s_resetn) begin
      if (stall_prev) begin
        checks++;
        if (tx_tvalid !== 1'b1 || {tx_tlast, tx_tkeep, tx_tdata} !== stall_beat) begin
          errors++;
          $display("FAIL stall_hold: got valid=%b beat=%h, required valid=1 beat=%h",
                   tx_tvalid, {tx_tlast, tx_tkeep, tx_tdata}, stall_beat);
        end
      end
      if (tx_tvalid && first_valid < 0) first_valid = cyc;
      if (tx_tvalid && tx_tready) gotq.push_back({tx_tlast, tx_tkeep, tx_tdata});
      if (frame_drop) drops++;
      stall_prev = tx_tvalid && !tx_tready;
      stall_beat = {tx_tlast, tx_tkeep, tx_tdata};
    end else begin
      stall_prev = 1'b0;
    end
    @(posedge mm2s_clk);
    #1;
    cyc++;
    if (rd_d) begin
      if (dq.size() > 0) dq.delete(0);
      else begin errors++; $display("FAIL data_underflow: rden=1 with data FIFO empty"); end
    end
    if (rd_c) begin
      if (cq.size() > 0) cq.delete(0);
      else begin errors++; $display("FAIL ctrl_underflow: rden=1 with ctrl FIFO empty"); end
    end
    refresh();
    tx_tready = ($urandom_range(99) < rdy_pct);
  endtask

  // Push a whole frame (data first, then ctrl) and record what the MAC must see
  task automatic send_frame(input byte_q_t fb, input logic [15:0] cb, input logic [15:0] ins,
                            input logic [15:0] init, input logic [1:0] cc);
    int          nb;
    byte_q_t     ob;
    logic [72:0] w;
    logic [15:0] cs;
    nb = (fb.size() + 7) / 8;
    ob = fb;
    cs = ref_csum(fb, cb, init);
    for (int k = 0; k < nb; k++) begin
      w = '0;
      for (int l = 0; l < 8; l++)
        if (8*k + l < fb.size()) begin
          w[8*l +: 8] = fb[8*k + l];
          w[64 + l]   = 1'b1;
        end
      w[72] = (k == nb - 1);
      dq.push_back(w);
    end
    cq.push_back({14'h0, cc, init, ins, cb});
    refresh();
`ifdef OFM_CSUM_EN
    if (nb > (1 << AW)) begin
      exp_drops++;
      return;
    end
    if (cc[0] && !ins[0] && (int'(ins) + 1 < fb.size())) begin
      ob[int'(ins)]     = cs[15:8];
      ob[int'(ins) + 1] = cs[7:0];
    end
`endif
    for (int k = 0; k < nb; k++) begin
      w = '0;
      for (int l = 0; l < 8; l++)
        if (8*k + l < ob.size()) begin
          w[8*l +: 8] = ob[8*k + l];
          w[64 + l]   = 1'b1;
        end
      w[72] = (k == nb - 1);
      expq.push_back(w);
    end
  endtask

  task automatic sb_clear();
    gotq.delete();
    expq.delete();
    drops = 0;
    exp_drops = 0;
    first_valid = -1;
    cyc = 0;
  endtask

  // Wait (bounded) for all expected beats, then compare stream and drop count
  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((gotq.size() < expq.size() || dq.size() > 0 || cq.size() > 0) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: got %0d beats, required %0d", name, gotq.size(), expq.size());
    end
    repeat (8) step();
    checks++;
    if (gotq.size() != expq.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d beats, required %0d", name, gotq.size(), expq.size());
    end
    for (int i = 0; i < gotq.size() && i < expq.size(); i++) begin
      checks++;
      if (gotq[i] !== expq[i]) begin
        errors++;
        $display("FAIL %s_beat%0d: got %h, required %h", name, i, gotq[i], expq[i]);
      end
    end
    checks++;
    if (drops != exp_drops) begin
      errors++;
      $display("FAIL %s_drops: got %0d, required %0d", name, drops, exp_drops);
    end
  endtask

  function automatic byte_q_t frame_t1();
    byte_q_t f;
    for (int i = 0; i < 64; i++) f.push_back(8'(i));
    return f;
  endfunction

  function automatic byte_q_t frame_t2();
    byte_q_t f;
    f = '{8'h45, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h00, 8'h00};
    return f;
  endfunction

  task automatic test_reset();
    mm2s_resetn = 1'b0;
    tx_tready = 1'b1;
    refresh();
    repeat (3) step();
    checks++;
    if ({tx_tvalid, tx_tlast, tx_tkeep, tx_tdata, ctrl_fifo_rden, data_fifo_rden, frame_drop} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b last=%b keep=%h data=%h crd=%b drd=%b drop=%b, required all 0",
               tx_tvalid, tx_tlast, tx_tkeep, tx_tdata, ctrl_fifo_rden, data_fifo_rden, frame_drop);
    end
    mm2s_resetn = 1'b1;
    repeat (4) step();
    checks++;
    if ({tx_tvalid, ctrl_fifo_rden, data_fifo_rden} !== 3'b000) begin
      errors++;
      $display("FAIL idle_quiet: got valid=%b crd=%b drd=%b, required 0", tx_tvalid, ctrl_fifo_rden, data_fifo_rden);
    end
  endtask

  task automatic test_passthrough();
    sb_clear();
    rdy_pct = 100;
    tx_tready = 1'b1;
    send_frame(frame_t1(), 16'd0, 16'd0, 16'd0, 2'b00);
    drain("t1", 200);
    checks++;
    if (first_valid < 0 || first_valid > 8 + 5) begin
      errors++;
      $display("FAIL t1_latency: got %0d cycles, required <= %0d", first_valid, 8 + 5);
    end
    checks++;
    if (dq.size() != 0 || cq.size() != 0) begin
      errors++;
      $display("FAIL t1_fifos_empty: got data=%0d ctrl=%0d entries, required 0", dq.size(), cq.size());
    end
  endtask

  task automatic test_csum_insert();
    logic [63:0] req;
    sb_clear();
    send_frame(frame_t2(), 16'd0, 16'd6, 16'd0, 2'b01);
    drain("t2", 100);
`ifdef OFM_CSUM_EN
    req = 64'hE3BA_0000_1C00_0045;
`else
    req = 64'h0000_0000_1C00_0045;
`endif
    checks++;
    if (gotq.size() < 1 || gotq[0][63:0] !== req) begin
      errors++;
      $display("FAIL t2_csum_bytes: got %h, required %h", (gotq.size() > 0) ? gotq[0][63:0] : 64'hx, req);
    end
  endtask

  task automatic test_carry_fold();
    byte_q_t f;
    sb_clear();
    f = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
    send_frame(f, 16'd0, 16'd6, 16'd0, 2'b01);
    drain("t3", 100);
    checks++;
    if (gotq.size() < 1 || gotq[0][63:0] !== 64'h0000_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL t3_fold: got %h, required %h", (gotq.size() > 0) ? gotq[0][63:0] : 64'hx,
               64'h0000_FFFF_FFFF_FFFF);
    end
  endtask

  task automatic test_backpressure();
    sb_clear();
    rdy_pct = 50;
    send_frame(frame_t1(), 16'd0, 16'd0, 16'd0, 2'b00);
    drain("t4", 400);
    rdy_pct = 100;
  endtask

  task automatic test_oversize_drop();
    byte_q_t f;
    sb_clear();
    for (int i = 0; i < 8 * ((1 << AW) + 1); i++) f.push_back(8'($urandom));
    send_frame(f, 16'd0, 16'd0, 16'd0, 2'b00);
    send_frame(frame_t2(), 16'd0, 16'd6, 16'd0, 2'b01);
    drain("t5", 4000);
  endtask

  task automatic test_reset_mid_frame();
    int n;
    sb_clear();
    rdy_pct = 100;
    send_frame(frame_t1(), 16'd0, 16'd0, 16'd0, 2'b00);
    n = 0;
    while (gotq.size() < 3 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL t6_wait: got %0d beats, required 3", gotq.size());
    end
    mm2s_resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (tx_tvalid !== 1'b0) begin
        errors++;
        $display("FAIL t6_reset_valid: got %b, required 0", tx_tvalid);
      end
    end
    cq.delete();
    dq.delete();
    refresh();
    mm2s_resetn = 1'b1;
    repeat (2) step();
    sb_clear();
    send_frame(frame_t2(), 16'd0, 16'd6, 16'd0, 2'b01);
    drain("t6", 100);
  endtask

  task automatic test_back_to_back();
    byte_q_t     f;
    int          len;
    logic [15:0] cb, ins;
    for (int r = 0; r < 5; r++) begin
      sb_clear();
      rdy_pct = 70;
      for (int k = 0; k < 3; k++) begin
        f.delete();
        len = int'($urandom_range(1, 48));
        for (int i = 0; i < len; i++) f.push_back(8'($urandom));
        cb  = 16'($urandom_range(0, len + 4));
        ins = 16'($urandom_range(0, len + 1));
        if ($urandom_range(3) != 0) ins[0] = 1'b0;
        send_frame(f, cb, ins, 16'($urandom), 2'($urandom));
      end
      drain("b2b", 600);
    end
    rdy_pct = 100;
  endtask

  initial begin
    mm2s_resetn = 1'b0;
    tx_tready = 1'b1;
    refresh();
    test_reset();
    test_passthrough();
    test_csum_insert();
    test_carry_fold();
    test_backpressure();
    test_oversize_drop();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
